// File: rtl/sipo_rx_if.sv
// Serial-input, word-output bundle between a PISO source (master) and sipo_rx (slave).
// The WIDTH parameter must match the WIDTH of the sipo_rx instance it connects to.
interface sipo_rx_if #(
   parameter int unsigned WIDTH = 8
);
   logic             ser;
   logic             shift_en;
   logic             sync;
   logic             ready;
   logic             ovr_clr;
   logic [WIDTH-1:0] dout;
   logic             valid;
   logic             overrun;
   logic             parity_err;

   modport master (
      output ser,
      output shift_en,
      output sync,
      output ready,
      output ovr_clr,
      input  dout,
      input  valid,
      input  overrun,
      input  parity_err
   );

   modport slave (
      input  ser,
      input  shift_en,
      input  sync,
      input  ready,
      input  ovr_clr,
      output dout,
      output valid,
      output overrun,
      output parity_err
   );
endinterface

// File: rtl/sipo_rx.sv
// LSB-first serial-to-parallel receiver with a one-word valid/ready holding register.
// Define SIPO_RX_PARITY_EN to append an even-parity bit to every frame.
module sipo_rx #(
   parameter int unsigned WIDTH = 8
) (
   input logic      clk,
   input logic      rst,
   sipo_rx_if.slave bus
);

`ifdef SIPO_RX_PARITY_EN
   localparam int unsigned FRAME = WIDTH + 1;
`else
   localparam int unsigned FRAME = WIDTH;
`endif
   localparam int unsigned CW = (FRAME > 1) ? $clog2(FRAME) : 1;
   localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

   logic [WIDTH-1:0] r_sh;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_dout;
   logic             r_valid;
   logic             r_ovr;

   logic [CW-1:0]    w_cnt_eff;
   logic [CW-1:0]    w_cnt_d;
   logic             w_complete;
   logic             w_data_bit;
   logic [WIDTH-1:0] w_shifted;
   logic [WIDTH-1:0] w_sh_d;
   logic [WIDTH-1:0] w_cand;
   logic             w_cand_perr;
   logic             w_accept;
   logic             w_load;
   logic             w_drop;
   logic [WIDTH-1:0] w_dout_d;
   logic             w_valid_d;
   logic             w_ovr_d;

   always_comb begin
      // sync restarts the frame, so a coincident strobe is treated as bit 0
      w_cnt_eff  = bus.sync ? '0 : r_cnt;
      w_complete = bus.shift_en && (w_cnt_eff == LAST);
      w_shifted  = {bus.ser, r_sh[WIDTH-1:1]};

`ifdef SIPO_RX_PARITY_EN
      // The parity bit completes the frame but never enters the shift register
      w_data_bit  = bus.shift_en && (w_cnt_eff != LAST);
      w_cand      = r_sh;
      w_cand_perr = (^r_sh) ^ bus.ser;
`else
      w_data_bit  = bus.shift_en;
      w_cand      = w_shifted;
      w_cand_perr = 1'b0;
`endif

      w_accept = !r_valid || bus.ready;
      w_load   = w_complete && w_accept;
      w_drop   = w_complete && !w_accept;

      w_sh_d = w_data_bit ? w_shifted : r_sh;

      w_cnt_d = r_cnt;
      if (bus.shift_en) begin
         w_cnt_d = w_complete ? '0 : (w_cnt_eff + 1'b1);
      end else if (bus.sync) begin
         w_cnt_d = '0;
      end

      w_dout_d  = w_load ? w_cand : r_dout;

      w_valid_d = r_valid;
      if (w_load) begin
         w_valid_d = 1'b1;
      end else if (r_valid && bus.ready) begin
         w_valid_d = 1'b0;
      end

      // A drop in the same cycle as a clear keeps the flag set
      w_ovr_d = r_ovr;
      if (w_drop) begin
         w_ovr_d = 1'b1;
      end else if (bus.ovr_clr) begin
         w_ovr_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sh    <= '0;
         r_cnt   <= '0;
         r_dout  <= '0;
         r_valid <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         r_sh    <= w_sh_d;
         r_cnt   <= w_cnt_d;
         r_dout  <= w_dout_d;
         r_valid <= w_valid_d;
         r_ovr   <= w_ovr_d;
      end
   end

`ifdef SIPO_RX_PARITY_EN
   logic r_perr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_perr <= 1'b0;
      end else if (w_load) begin
         r_perr <= w_cand_perr;
      end
   end

   assign bus.parity_err = r_perr;
`else
   // Bit 0 is shifted out before it is ever read in the parity-free frame
   logic w_unused_sh0;
   logic w_unused_perr;

   assign w_unused_sh0   = r_sh[0];
   assign w_unused_perr  = w_cand_perr;
   assign bus.parity_err = 1'b0;
`endif

   assign bus.dout    = r_dout;
   assign bus.valid   = r_valid;
   assign bus.overrun = r_ovr;

endmodule

// File: tb/tb_sipo_rx.sv
// Directed bench for sipo_rx with a scoreboard of expected delivered words.
// Honours SIPO_RX_PARITY_EN to exercise the parity frame format.
module tb_sipo_rx;

`ifdef SIPO_RX_PARITY_EN
   localparam int  FRAME = 9;
   localparam bit  PAR   = 1'b1;
`else
   localparam int  FRAME = 8;
   localparam bit  PAR   = 1'b0;
`endif

   typedef struct packed {
      logic [7:0] d;
      logic       p;
   } exp_t;

   logic clk;
   logic rst;

   sipo_rx_if #(.WIDTH(8)) bus ();

   sipo_rx #(.WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_total = 0;
   int   n_pass  = 0;
   int   cycle   = 0;
   exp_t sb[$];
   int   hs_times[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   function automatic logic [FRAME-1:0] mk_frame(input logic [7:0] w, input logic p);
      logic [8:0] f;
      f = {p, w};
      return f[FRAME-1:0];
   endfunction

   task automatic push_exp(input logic [7:0] w, input logic pbit);
      exp_t e;
      e.d = w;
      e.p = PAR ? ((^w) ^ pbit) : 1'b0;
      sb.push_back(e);
   endtask

   // One clock: drive at the falling edge, resolve the handshake seen at the next rising edge.
   task automatic cyc(input logic s, input logic en, input logic sy, input logic rdy,
                      input logic oc);
      logic       hs;
      logic [7:0] hs_d;
      logic       hs_p;
      exp_t       e;
      bus.ser      = s;
      bus.shift_en = en;
      bus.sync     = sy;
      bus.ready    = rdy;
      bus.ovr_clr  = oc;
      hs   = bus.valid && rdy;
      hs_d = bus.dout;
      hs_p = bus.parity_err;
      @(posedge clk);
      @(negedge clk);
      cycle++;
      if (hs) begin
         hs_times.push_back(cycle);
         if (sb.size() == 0) begin
            chk("unexpected_word", {24'd0, hs_d}, 32'hFFFF_FFFF);
         end else begin
            e = sb.pop_front();
            chk("sb_dout", {24'd0, hs_d}, {24'd0, e.d});
            chk("sb_parity_err", {31'd0, hs_p}, {31'd0, e.p});
         end
      end
   endtask

   task automatic send_word(input logic [7:0] w, input logic pbit, input logic rdy);
      logic [FRAME-1:0] f;
      f = mk_frame(w, pbit);
      for (int i = 0; i < FRAME; i++) cyc(f[i], 1'b1, 1'b0, rdy, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [FRAME-1:0] f;
      int               hs0;

      rst          = 1'b1;
      bus.ser      = 1'b0;
      bus.shift_en = 1'b0;
      bus.sync     = 1'b0;
      bus.ready    = 1'b0;
      bus.ovr_clr  = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_dout", {24'd0, bus.dout}, 32'd0);
      chk("rst_valid", {31'd0, bus.valid}, 32'd0);
      chk("rst_overrun", {31'd0, bus.overrun}, 32'd0);
      chk("rst_parity_err", {31'd0, bus.parity_err}, 32'd0);
      rst = 1'b0;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // First word A5 with ready low; valid must appear only after the last bit's edge
      f = mk_frame(8'hA5, ^8'hA5);
      push_exp(8'hA5, ^8'hA5);
      for (int i = 0; i < FRAME - 1; i++) cyc(f[i], 1'b1, 1'b0, 1'b0, 1'b0);
      chk("valid_before_last", {31'd0, bus.valid}, 32'd0);
      cyc(f[FRAME-1], 1'b1, 1'b0, 1'b0, 1'b0);
      chk("valid_after_last", {31'd0, bus.valid}, 32'd1);
      chk("dout_a5", {24'd0, bus.dout}, 32'h0000_00A5);

      // Second word while full: dropped, overrun set, A5 held
      send_word(8'h5A, ^8'h5A, 1'b0);
      chk("overrun_set", {31'd0, bus.overrun}, 32'd1);
      chk("dout_held", {24'd0, bus.dout}, 32'h0000_00A5);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("overrun_cleared", {31'd0, bus.overrun}, 32'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("valid_consumed", {31'd0, bus.valid}, 32'd0);

      // Back-to-back words with ready high
      hs0 = hs_times.size();
      push_exp(8'h01, ^8'h01);
      send_word(8'h01, ^8'h01, 1'b1);
      push_exp(8'hFF, ^8'hFF);
      send_word(8'hFF, ^8'hFF, 1'b1);
      push_exp(8'h3C, ^8'h3C);
      send_word(8'h3C, ^8'h3C, 1'b1);
      repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("b2b_count", hs_times.size() - hs0, 32'd3);
      if (hs_times.size() - hs0 == 3) begin
         chk("b2b_gap1", hs_times[hs0+1] - hs_times[hs0], FRAME);
         chk("b2b_gap2", hs_times[hs0+2] - hs_times[hs0+1], FRAME);
      end
      chk("b2b_overrun", {31'd0, bus.overrun}, 32'd0);
      chk("b2b_sb_empty", sb.size(), 32'd0);

      // Partial word discarded by sync; the strobe with sync is bit 0
      hs0 = hs_times.size();
      repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      push_exp(8'h01, ^8'h01);
      f = mk_frame(8'h01, ^8'h01);
      cyc(f[0], 1'b1, 1'b1, 1'b1, 1'b0);
      for (int i = 1; i < FRAME; i++) cyc(f[i], 1'b1, 1'b0, 1'b1, 1'b0);
      repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("sync_count", hs_times.size() - hs0, 32'd1);
      chk("sync_sb_empty", sb.size(), 32'd0);

      // Reset mid-word while full and overrun set
      send_word(8'hC3, ^8'hC3, 1'b0);
      send_word(8'h11, ^8'h11, 1'b0);
      chk("pre_rst_overrun", {31'd0, bus.overrun}, 32'd1);
      repeat (5) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_dout", {24'd0, bus.dout}, 32'd0);
      chk("async_rst_valid", {31'd0, bus.valid}, 32'd0);
      chk("async_rst_overrun", {31'd0, bus.overrun}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      hs0 = hs_times.size();
      push_exp(8'h96, ^8'h96);
      send_word(8'h96, ^8'h96, 1'b1);
      repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("post_rst_count", hs_times.size() - hs0, 32'd1);
      chk("post_rst_sb_empty", sb.size(), 32'd0);

`ifdef SIPO_RX_PARITY_EN
      // Good parity on 03, bad parity on 07 (word still delivered)
      hs0 = hs_times.size();
      push_exp(8'h03, 1'b0);
      send_word(8'h03, 1'b0, 1'b1);
      push_exp(8'h07, 1'b0);
      send_word(8'h07, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("par_err_07", {31'd0, bus.parity_err}, 32'd1);
      chk("par_dout_07", {24'd0, bus.dout}, 32'h0000_0007);
      repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("par_count", hs_times.size() - hs0, 32'd2);
      chk("par_sb_empty", sb.size(), 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
